// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: links the sequencer to the instruction store and the register/ALU datapath.
//   master (sequencer): drives im_addr, register-file/latch strobes, alu_op and imm_ext; reads im_data and alu_zero.
//   slave  (datapath):  the mirror image.
interface instr_sequencer_if #(parameter int AW = 3);
  logic [AW-1:0] im_addr;
  logic [31:0]   im_data;
  logic          alu_zero;
  logic [1:0]    rf_ra_a;
  logic [1:0]    rf_ra_b;
  logic          a_en;
  logic          b_en;
  logic          b_sel;
  logic [31:0]   imm_ext;
  logic [2:0]    alu_op;
  logic          out_en;
  logic          rf_we;
  logic [1:0]    rf_wa;
  modport master (
    output im_addr, rf_ra_a, rf_ra_b, a_en, b_en, b_sel, imm_ext, alu_op, out_en, rf_we, rf_wa,
    input  im_data, alu_zero
  );
  modport slave (
    input  im_addr, rf_ra_a, rf_ra_b, a_en, b_en, b_sel, imm_ext, alu_op, out_en, rf_we, rf_wa,
    output im_data, alu_zero
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/WB controller for the 4-register/ALU datapath.
//   clk, RST (async, active-low), start: control inputs.
//   bus: store address/data plus datapath strobes (master side).
//   pc, busy, done, timeout: status outputs.
module instr_sequencer #(
  parameter int IM_DEPTH  = 8,
  parameter int MAX_INSTR = 64
) (
  input  logic                        clk,
  input  logic                        RST,
  input  logic                        start,
  instr_sequencer_if.master           bus,
  output logic [$clog2(IM_DEPTH)-1:0] pc,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout
);
  localparam int PW = $clog2(IM_DEPTH);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, DONE} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic [3:0]    op;
  logic          jump, taken;
  logic          unused_ir;
  assign op        = ir_q[31:28];
  assign jump      = op == 4'd8;
  assign taken     = op == 4'd7 && bus.alu_zero;
  assign unused_ir = ^ir_q[21:16];
  assign bus.im_addr = pc_q;
  assign bus.imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc      = pc_q;
  assign busy    = state_q inside {FETCH, DECODE, EXEC, WB};
  assign done    = state_q == DONE;
  assign timeout = timeout_q && state_q == DONE;
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    bus.rf_ra_a = 2'd0;
    bus.rf_ra_b = 2'd0;
    bus.a_en    = 1'b0;
    bus.b_en    = 1'b0;
    bus.b_sel   = 1'b0;
    bus.alu_op  = 3'd0;
    bus.out_en  = 1'b0;
    bus.rf_we   = 1'b0;
    bus.rf_wa   = 2'd0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d   = FETCH;
        pc_d      = '0;
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
      FETCH: begin
        ir_d    = bus.im_data;
        state_d = DECODE;
      end
      DECODE: if (op == 4'hF) state_d = DONE;
      else begin
        bus.rf_ra_a = ir_q[25:24];
        bus.rf_ra_b = ir_q[23:22];
        bus.a_en    = 1'b1;
        bus.b_en    = 1'b1;
        bus.b_sel   = op == 4'd6;
        state_d     = EXEC;
      end
      EXEC: begin
        // ALU ops 1..5 map to codes 0..4; BEQ compares by subtraction; everything else adds.
        bus.alu_op = (op >= 4'd1 && op <= 4'd5) ? 3'(op - 4'd1) : (op == 4'd7 ? 3'd1 : 3'd0);
        bus.out_en = 1'b1;
        state_d    = WB;
      end
      WB: begin
        bus.rf_we = op >= 4'd1 && op <= 4'd6;
        bus.rf_wa = ir_q[27:26];
        // Branch offset is the signed low PC-width imm bits; modulo PC arithmetic makes unsigned add equivalent.
        pc_d      = jump ? ir_q[PW-1:0] : taken ? pc_q + PW'(1) + ir_q[PW-1:0] : pc_q + PW'(1);
        cnt_d     = cnt_q + 8'd1;
        if (cnt_d == 8'(MAX_INSTR)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else state_d = (pc_q == PW'(IM_DEPTH - 1) && !jump && !taken) ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle controller that runs the 8-entry instruction store through the shared 4-register/ALU datapath (r0–r3, A, B, ALUout). It fetches each 32-bit instruction, decodes it, and drives the register-file read/write strobes, A/B latch enables and ALU opcode. It resolves branches and jumps and stops on HALT, at the end of the store, or on a watchdog limit. It sits between the instruction store and the datapath, replacing hard-wired sequencing inside `control`.

## Interface

**Parameters**
- `IM_DEPTH`, 8: instruction store entries. It must be a power of 2, and PC width is log2(`IM_DEPTH`).
- `MAX_INSTR`, 64: completed-instruction limit before forced stop. Range 1–255.

**Ports**
- `clk` in 1: rising-edge clock.
- `RST` in 1: asynchronous, active-low reset.
- `start` in 1: begin execution at PC 0. Sampled only in IDLE or DONE.
- `im_addr` out 3: instruction store read address, equal to `pc`.
- `im_data` in 32: instruction word at `im_addr`, combinational from the store.
- `alu_zero` in 1: datapath flag, high when the registered ALUout is 0.
- `rf_ra_a` out 2: register read address for the A latch.
- `rf_ra_b` out 2: register read address for the B latch.
- `a_en` out 1: load the A latch.
- `b_en` out 1: load the B latch.
- `b_sel` out 1: B source select. 0 = register, 1 = `imm_ext`.
- `imm_ext` out 32: sign-extended `ir[15:0]`.
- `alu_op` out 3: ALU operation. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- `out_en` out 1: load ALUout.
- `rf_we` out 1: register-file write strobe.
- `rf_wa` out 2: register-file write address.
- `pc` out 3: current program counter.
- `busy` out 1: high in FETCH, DECODE, EXEC and WB.
- `done` out 1: high in DONE.
- `timeout` out 1: high in DONE when the stop was forced by the watchdog.

## Operation

**Instruction format**
- `[31:28]` op, `[27:26]` rd, `[25:24]` rs, `[23:22]` rt, `[15:0]` imm.

**Opcodes**
- 0 NOP
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT: rd = rs op rt
- 6 ADDI: rd = rs + sext(imm)
- 7 BEQ: if rs == rt, pc = pc + 1 + imm[2:0], with imm[2:0] taken as signed
- 8 JMP: pc = imm[2:0]
- 15 HALT
- Any other opcode behaves as NOP.

**FSM states:** IDLE, FETCH, DECODE, EXEC, WB, DONE.

- **IDLE:** `start` → FETCH. Clears `pc`, `instr_cnt` and `timeout`.
- **FETCH:** latch `ir` ← `im_data`, then go to DECODE.
- **DECODE:**
  - If op is HALT → DONE. HALT is not counted.
  - Otherwise drive `rf_ra_a`=rs, `rf_ra_b`=rt, `a_en`=1, `b_en`=1, and `b_sel`=1 only for ADDI; then go to EXEC.
- **EXEC:** drive `alu_op` (ALU ops map to codes 0–4; ADDI → ADD; BEQ → SUB; others → ADD) and `out_en`=1. Go to WB.
- **WB:**
  - For ops 1–6, drive `rf_we`=1 with `rf_wa`=rd.
  - Update `pc`:
    - JMP: `pc` ← imm[2:0].
    - BEQ with `alu_zero`=1: `pc` ← pc + 1 + off.
    - All other cases: `pc` ← pc + 1.
  - `instr_cnt` increments.
  - Next state:
    - → DONE with `timeout`=1 if the incremented `instr_cnt` equals `MAX_INSTR`.
    - Otherwise → DONE if `pc` == 7 and no jump or taken branch occurred.
    - Otherwise → FETCH.
- **DONE:** hold `done`=1. `start` → FETCH and performs the same clears as IDLE.

**Arithmetic and ordering rules**
- PC arithmetic is modulo 8, so branch and jump targets wrap.
- The watchdog check takes priority over end-of-store.
- End-of-store applies only to sequential fall-through from pc 7. A taken branch or JMP at pc 7 continues execution.

**Outputs**
- All strobes (`a_en`, `b_en`, `out_en`, `rf_we`) are Moore outputs decoded from state and `ir`.
- They are low in IDLE, FETCH and DONE.

## Timing

- **Reset:** while `RST`=0, state is IDLE; `pc`, `ir` and `instr_cnt` are 0; every output is 0.
- **Reset mid-operation:** asserting reset at any time aborts at once. Any `rf_we` in flight is dropped.
- **Latency:**
  - Each executed instruction takes 4 cycles: FETCH, DECODE, EXEC, WB.
  - HALT takes 2 cycles.
  - `start` sampled at edge k → FETCH from edge k.
  - For n non-HALT instructions, `done` rises at edge k + 4n.
- **Data timing:**
  - `alu_zero` is sampled in WB and reflects ALUout as loaded at the end of EXEC.
  - The register write commits at the WB→next edge.
  - The next FETCH reads the updated `pc`.
- **start handling:**
  - `start` is ignored while `busy`=1.
  - `start` held high in DONE restarts on the next edge.

## Test plan

1. **ADD program.** r0=3, r1=4, IM0=ADD r2,r0,r1, IM1–7=NOP, pulse `start`.
   - Required: `rf_we` with `rf_wa`=2 in cycle 4; ALUout=7; `done` at start+32; `timeout`=0.
2. **ADDI sign extension.** IM0=ADDI r1,r0,imm=0xFFFF with r0=5, then HALT.
   - Required: B latch receives 0xFFFFFFFF, ALUout=4, and `done` at start+6.
3. **Backward branch loop.**
   - Program: IM0=ADDI r0,r0,1; IM1=BEQ r0,r3,+1 (r3=3); IM2=JMP 0; IM3=HALT.
   - Required: r0 ends at 3; exactly 8 completed instructions; `done` with `timeout`=0.
4. **Watchdog.** IM0=JMP 0, `MAX_INSTR`=64.
   - Required: `done` and `timeout` both high at start+256; `pc`=0.
5. **Wrap-around.** IM7=BEQ r0,r0,+0.
   - Required: taken branch to pc 0 (mod 8) and execution continues; no `done` at pc 7.
6. **Reset mid-operation.** Drive `RST` low during EXEC of IM2.
   - Required: all outputs 0 immediately, no `rf_we`, state IDLE.
   - After `RST` returns high, `start` re-runs the program from pc 0.
